chan_mem_arb: RTL

CHAN_MEM_ARB -- requirements
Module: chan_mem_arb

---
 rtl/chan_mem_arb_pkg.sv | 34 +++
 rtl/chan_mem_arb_if.sv | 22 ++
 rtl/chan_mem_arb.sv | 112 +++++++++++
 3 files changed

// File: rtl/chan_mem_arb_pkg.sv
// Shared types and widths for the channel-state memory arbiter.
package chan_mem_arb_pkg;

  localparam int unsigned CH_WORD_AW = 7;
  localparam int unsigned CH_DATA_W  = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CH_BE_W    = CH_DATA_W / BYTE_W;
  localparam int unsigned LANE_W     = 2;
  localparam int unsigned HOST_AW    = CH_WORD_AW + LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RDCAP = 3'd3,
    ST_DONE  = 3'd4
  } host_st_e;

  // Host byte address split into channel-state word and byte lane
  typedef struct packed {
    logic [CH_WORD_AW-1:0] word;
    logic [LANE_W-1:0]     lane;
  } host_addr_t;

  function automatic logic [CH_BE_W-1:0] lane_be(input logic [LANE_W-1:0] lane);
    return CH_BE_W'(1) << lane;
  endfunction

  function automatic logic [BYTE_W-1:0] lane_byte(input logic [CH_DATA_W-1:0] word,
                                                  input logic [LANE_W-1:0]    lane);
    return word[{lane, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/chan_mem_arb_if.sv
// Host byte-access port: level requests held until a one-cycle ack.
interface chan_mem_arb_if;
  import chan_mem_arb_pkg::*;

  host_addr_t          host_addr;
  logic [BYTE_W-1:0]   host_wdata;
  logic                host_wr_req;
  logic                host_rd_req;
  logic                host_ack;
  logic [BYTE_W-1:0]   host_rdata;

  modport master (
    output host_addr, host_wdata, host_wr_req, host_rd_req,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_addr, host_wdata, host_wr_req, host_rd_req,
    output host_ack, host_rdata
  );

endinterface

// File: rtl/chan_mem_arb.sv
// Arbitrates a byte-wide host port against the channel controller on the
// channel-state RAM, and gates the period sync strobe around host accesses.
module chan_mem_arb
  import chan_mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  chan_mem_arb_if.slave         host,
  input  logic                  sync_in,
  output logic                  sync_out,
  output logic                  sync_ovr,
  input  logic                  ctl_busy,
  input  logic [CH_WORD_AW-1:0] ctl_rd_addr,
  input  logic [CH_WORD_AW-1:0] ctl_wr_addr,
  input  logic [CH_DATA_W-1:0]  ctl_wr_data,
  input  logic                  ctl_wr_stb,
  output logic [CH_DATA_W-1:0]  ctl_rd_data,
  output logic [CH_WORD_AW-1:0] mem_rd_addr,
  input  logic [CH_DATA_W-1:0]  mem_rd_data,
  output logic [CH_WORD_AW-1:0] mem_wr_addr,
  output logic [CH_DATA_W-1:0]  mem_wr_data,
  output logic [CH_BE_W-1:0]    mem_wr_be,
  output logic                  mem_wr_stb
);

  host_st_e          r_st;
  host_st_e          w_st_nxt;
  host_addr_t        r_addr;
  logic [BYTE_W-1:0] r_wdata;
  logic [BYTE_W-1:0] r_host_rdata;
  logic              r_host_ack;
  logic              r_sync_pend;
  logic              r_sync_out;
  logic              r_sync_ovr;
  logic              w_grant_ok;
  logic              w_sync_fire;

  // Host may only start while the controller is parked and no sync is in flight
  assign w_grant_ok  = (r_st == ST_IDLE) && !ctl_busy && !r_sync_pend && !r_sync_out;
  assign w_sync_fire = (r_st == ST_IDLE) && r_sync_pend && !ctl_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= ST_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE: begin
        if (w_grant_ok && host.host_wr_req)      w_st_nxt = ST_WR;
        else if (w_grant_ok && host.host_rd_req) w_st_nxt = ST_RD;
      end
      ST_WR:    w_st_nxt = ST_DONE;
      ST_RD:    w_st_nxt = ST_RDCAP;
      ST_RDCAP: w_st_nxt = ST_DONE;
      ST_DONE:  w_st_nxt = ST_IDLE;
      default:  w_st_nxt = ST_IDLE;
    endcase
  end

  // Memory port mux; a controller write in WR takes the port and drops the host byte
  always_comb begin
    mem_rd_addr = ctl_rd_addr;
    mem_wr_addr = ctl_wr_addr;
    mem_wr_data = ctl_wr_data;
    mem_wr_be   = '1;
    mem_wr_stb  = ctl_wr_stb;
    case (r_st)
      ST_WR: begin
        if (!ctl_wr_stb) begin
          mem_wr_addr = r_addr.word;
          mem_wr_data = {CH_BE_W{r_wdata}};
          mem_wr_be   = lane_be(r_addr.lane);
          mem_wr_stb  = 1'b1;
        end
      end
      ST_RD:   mem_rd_addr = r_addr.word;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_host_rdata <= '0;
      r_host_ack   <= 1'b0;
      r_sync_pend  <= 1'b0;
      r_sync_out   <= 1'b0;
      r_sync_ovr   <= 1'b0;
    end else begin
      if ((r_st == ST_IDLE) && (w_st_nxt != ST_IDLE)) begin
        r_addr  <= host.host_addr;
        r_wdata <= host.host_wdata;
      end
      if (r_st == ST_RDCAP) r_host_rdata <= lane_byte(mem_rd_data, r_addr.lane);
      r_host_ack <= (w_st_nxt == ST_DONE);
      // A sync arriving while one is pending merges into it rather than queuing
      r_sync_out  <= w_sync_fire;
      r_sync_ovr  <= sync_in && (r_sync_pend || ctl_busy);
      r_sync_pend <= w_sync_fire ? 1'b0 : (r_sync_pend || sync_in);
    end
  end

  assign host.host_ack   = r_host_ack;
  assign host.host_rdata = r_host_rdata;
  assign sync_out        = r_sync_out;
  assign sync_ovr        = r_sync_ovr;
  assign ctl_rd_data     = mem_rd_data;

endmodule
